// File: rtl/raster_iter_pkg.sv
// Shared types and helpers for the sample iterator.
// Holds FSM states, box indices and the MSAA step decode.
package raster_iter_pkg;

    typedef enum logic {
        WAIT = 1'b0,
        TEST = 1'b1
    } state_e;

    localparam int LL = 0;
    localparam int UR = 1;

    // One-hot MSAA select to grid step in fixed point.
    function automatic logic [31:0] step_of(
        input logic [3:0] sub,
        input int         radix
    );
        logic [31:0] s;
        s = 32'd1 << radix;
        unique case (1'b1)
            sub[3]:  s = 32'd1 << radix;
            sub[2]:  s = 32'd1 << (radix - 1);
            sub[1]:  s = 32'd1 << (radix - 2);
            sub[0]:  s = 32'd1 << (radix - 3);
            default: s = 32'd1 << radix;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/sample_iter_multi.sv
// Sample iterator: latches a triangle and walks its bounding box
// in raster order, NUM_SAMPLES x-adjacent samples per cycle.
module sample_iter_multi
    import raster_iter_pkg::*;
#(
    parameter int SIGFIG      = 24,
    parameter int RADIX       = 10,
    parameter int VERTS       = 3,
    parameter int AXIS        = 3,
    parameter int COLORS      = 3,
    parameter int NUM_SAMPLES = 2
) (
    input  logic                                         clk,
    input  logic                                         rst,
    input  logic signed [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_R13S,
    input  logic [COLORS-1:0][SIGFIG-1:0]                color_R13U,
    input  logic signed [1:0][1:0][SIGFIG-1:0]           box_R13S,
    input  logic                                         validTri_R13H,
    input  logic [3:0]                                   subSample_RnnnnU,
    output logic                                         halt_RnnnnL,
    output logic signed [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_R14S,
    output logic [COLORS-1:0][SIGFIG-1:0]                color_R14U,
    output logic signed [NUM_SAMPLES-1:0][1:0][SIGFIG-1:0] sample_R14S,
    output logic [NUM_SAMPLES-1:0]                       validSamp_R14H
);

    localparam int W = SIGFIG + 1;

    // Sign-extend by one bit so sums near full range cannot wrap.
    function automatic logic signed [W-1:0] ext(input logic [SIGFIG-1:0] v);
        return {v[SIGFIG-1], v};
    endfunction

    state_e            state;
    logic [SIGFIG-1:0] ll_x;
    logic [SIGFIG-1:0] ur_x;
    logic [SIGFIG-1:0] ur_y;
    logic [SIGFIG-1:0] cur_x;
    logic [SIGFIG-1:0] cur_y;
    logic [SIGFIG-1:0] step;

    logic [SIGFIG-1:0] step_in;
    logic [SIGFIG-1:0] mask;
    logic [SIGFIG-1:0] nll_x;
    logic [SIGFIG-1:0] nll_y;
    logic              empty_in;
    logic              accept;

    logic              wrap;
    logic              last_cycle;
    logic [SIGFIG-1:0] adv_x;
    logic [SIGFIG-1:0] adv_y;

    logic [SIGFIG-1:0] pos_x;
    logic [SIGFIG-1:0] pos_y;
    logic [SIGFIG-1:0] lim_x;
    logic [SIGFIG-1:0] pos_step;
    logic [NUM_SAMPLES-1:0][1:0][SIGFIG-1:0] nxt_sample;
    logic [NUM_SAMPLES-1:0]                  nxt_valid;

    assign step_in = SIGFIG'(step_of(subSample_RnnnnU, RADIX));
    assign mask    = ~(step_in - SIGFIG'(1));
    assign nll_x   = box_R13S[LL][0] & mask;
    assign nll_y   = box_R13S[LL][1] & mask;
    assign empty_in = (ext(box_R13S[UR][0]) < ext(nll_x)) ||
                      (ext(box_R13S[UR][1]) < ext(nll_y));

    assign halt_RnnnnL = (state == WAIT) || last_cycle;
    assign accept      = validTri_R13H && halt_RnnnnL;

    // Row-wrap and end-of-box detection for the current position.
    always_comb begin
        logic signed [W-1:0] span;
        span = ext(cur_x);
        for (int k = 0; k < NUM_SAMPLES; k++) begin
            span = span + ext(step);
        end
        wrap       = span > ext(ur_x);
        last_cycle = (state == TEST) && wrap &&
                     ((ext(cur_y) + ext(step)) > ext(ur_y));
        adv_x      = wrap ? ll_x : span[SIGFIG-1:0];
        adv_y      = wrap ? cur_y + step : cur_y;
    end

    // Sample positions and valids for the position loaded next.
    always_comb begin
        logic signed [W-1:0] sx;
        pos_x    = accept ? nll_x : adv_x;
        pos_y    = accept ? nll_y : adv_y;
        lim_x    = accept ? box_R13S[UR][0] : ur_x;
        pos_step = accept ? step_in : step;
        sx       = ext(pos_x);
        for (int k = 0; k < NUM_SAMPLES; k++) begin
            nxt_sample[k][0] = sx[SIGFIG-1:0];
            nxt_sample[k][1] = pos_y;
            nxt_valid[k]     = sx <= ext(lim_x);
            sx               = sx + ext(pos_step);
        end
    end

    // Iterator FSM with registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= WAIT;
            ll_x           <= '0;
            ur_x           <= '0;
            ur_y           <= '0;
            cur_x          <= '0;
            cur_y          <= '0;
            step           <= '0;
            tri_R14S       <= '0;
            color_R14U     <= '0;
            sample_R14S    <= '0;
            validSamp_R14H <= '0;
        end else if (accept) begin
            assert ($onehot(subSample_RnnnnU));
            if (empty_in) begin
                state          <= WAIT;
                validSamp_R14H <= '0;
            end else begin
                state          <= TEST;
                tri_R14S       <= tri_R13S;
                color_R14U     <= color_R13U;
                step           <= step_in;
                ll_x           <= nll_x;
                ur_x           <= box_R13S[UR][0];
                ur_y           <= box_R13S[UR][1];
                cur_x          <= nll_x;
                cur_y          <= nll_y;
                sample_R14S    <= nxt_sample;
                validSamp_R14H <= nxt_valid;
            end
        end else if (state == TEST) begin
            if (last_cycle) begin
                state          <= WAIT;
                validSamp_R14H <= '0;
            end else begin
                cur_x          <= adv_x;
                cur_y          <= adv_y;
                sample_R14S    <= nxt_sample;
                validSamp_R14H <= nxt_valid;
            end
        end
    end

endmodule

// File: tb/tb_sample_iter_multi.sv
// Directed testbench for sample_iter_multi.
// Each scenario task checks its own expected values inline.
module tb_sample_iter_multi;

    localparam int SF = 24;

    typedef logic signed [1:0][1:0][SF-1:0] samp_t;

    logic                          clk = 1'b0;
    logic                          rst;
    logic signed [2:0][2:0][SF-1:0] tri_in;
    logic [2:0][SF-1:0]            color_in;
    logic signed [1:0][1:0][SF-1:0] box_in;
    logic                          valid_in;
    logic [3:0]                    sub_in;
    logic                          halt;
    logic signed [2:0][2:0][SF-1:0] tri_out;
    logic [2:0][SF-1:0]            color_out;
    samp_t                         samp_out;
    logic [1:0]                    vsamp;

    int checks = 0;
    int errors = 0;

    sample_iter_multi dut (
        .clk              (clk),
        .rst              (rst),
        .tri_R13S         (tri_in),
        .color_R13U       (color_in),
        .box_R13S         (box_in),
        .validTri_R13H    (valid_in),
        .subSample_RnnnnU (sub_in),
        .halt_RnnnnL      (halt),
        .tri_R14S         (tri_out),
        .color_R14U       (color_out),
        .sample_R14S      (samp_out),
        .validSamp_R14H   (vsamp)
    );

    always #5 clk = ~clk;

    function automatic samp_t mk(input int x0, input int x1, input int y);
        samp_t s;
        s[0][0] = SF'(x0);
        s[0][1] = SF'(y);
        s[1][0] = SF'(x1);
        s[1][1] = SF'(y);
        return s;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int lx, input int ly, input int ux, input int uy,
                        input logic [3:0] sub, input int seed);
        box_in[0][0] = SF'(lx);
        box_in[0][1] = SF'(ly);
        box_in[1][0] = SF'(ux);
        box_in[1][1] = SF'(uy);
        sub_in       = sub;
        for (int v = 0; v < 3; v++)
            for (int a = 0; a < 3; a++)
                tri_in[v][a] = SF'(seed * 16 + v * 3 + a + 1);
        for (int c = 0; c < 3; c++)
            color_in[c] = SF'(seed * 256 + c + 7);
    endtask

    task automatic send(input int lx, input int ly, input int ux, input int uy,
                        input logic [3:0] sub, input int seed);
        load(lx, ly, ux, uy, sub, seed);
        valid_in = 1'b1;
        tick();
        valid_in = 1'b0;
    endtask

    task automatic test_reset;
        rst      = 1'b1;
        valid_in = 1'b0;
        load(0, 0, 0, 0, 4'b1000, 0);
        tick();
        tick();
        rst = 1'b0;
        checks++;
        if (halt !== 1'b1) begin
            errors++;
            $display("FAIL reset_halt got %b want 1", halt);
        end
        checks++;
        if (vsamp !== 2'b00) begin
            errors++;
            $display("FAIL reset_valid got %b want 00", vsamp);
        end
        checks++;
        if (samp_out !== '0 || tri_out !== '0 || color_out !== '0) begin
            errors++;
            $display("FAIL reset_data got %h %h %h want 0", samp_out, tri_out, color_out);
        end
    endtask

    task automatic test_msaa1;
        samp_t exp_s [4];
        exp_s[0] = mk(0, 1024, 0);
        exp_s[1] = mk(2048, 3072, 0);
        exp_s[2] = mk(0, 1024, 1024);
        exp_s[3] = mk(2048, 3072, 1024);
        send(0, 0, 3072, 1024, 4'b1000, 1);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (samp_out !== exp_s[i] || vsamp !== 2'b11) begin
                errors++;
                $display("FAIL msaa1_c%0d got %h/%b want %h/11", i, samp_out, vsamp, exp_s[i]);
            end
            checks++;
            if (halt !== (i == 3)) begin
                errors++;
                $display("FAIL msaa1_halt%0d got %b want %b", i, halt, i == 3);
            end
            if (i < 3) tick();
        end
        checks++;
        if (tri_out[2][1] !== SF'(16 + 8) || color_out[1] !== SF'(256 + 8)) begin
            errors++;
            $display("FAIL msaa1_latch got %h %h want %h %h",
                     tri_out[2][1], color_out[1], SF'(24), SF'(264));
        end
        tick();
        checks++;
        if (vsamp !== 2'b00 || halt !== 1'b1) begin
            errors++;
            $display("FAIL msaa1_done got v=%b h=%b want v=00 h=1", vsamp, halt);
        end
    endtask

    task automatic test_odd_width;
        send(0, 0, 2048, 0, 4'b1000, 2);
        checks++;
        if (samp_out !== mk(0, 1024, 0) || vsamp !== 2'b11) begin
            errors++;
            $display("FAIL odd_c0 got %h/%b want %h/11", samp_out, vsamp, mk(0, 1024, 0));
        end
        tick();
        checks++;
        if (samp_out !== mk(2048, 3072, 0) || vsamp !== 2'b01 || halt !== 1'b1) begin
            errors++;
            $display("FAIL odd_c1 got %h/%b h=%b want %h/01 h=1",
                     samp_out, vsamp, halt, mk(2048, 3072, 0));
        end
        tick();
        checks++;
        if (vsamp !== 2'b00) begin
            errors++;
            $display("FAIL odd_done got %b want 00", vsamp);
        end
    endtask

    task automatic test_msaa4_snap;
        send(300, 0, 1023, 0, 4'b0100, 3);
        checks++;
        if (samp_out !== mk(0, 512, 0) || vsamp !== 2'b11 || halt !== 1'b1) begin
            errors++;
            $display("FAIL msaa4_c0 got %h/%b h=%b want %h/11 h=1",
                     samp_out, vsamp, halt, mk(0, 512, 0));
        end
        tick();
        checks++;
        if (vsamp !== 2'b00 || samp_out !== mk(0, 512, 0)) begin
            errors++;
            $display("FAIL msaa4_done got %h/%b want %h/00", samp_out, vsamp, mk(0, 512, 0));
        end
    endtask

    task automatic test_back_to_back;
        send(0, 0, 1024, 1024, 4'b1000, 4);
        checks++;
        if (samp_out !== mk(0, 1024, 0) || vsamp !== 2'b11 || halt !== 1'b0) begin
            errors++;
            $display("FAIL b2b_a0 got %h/%b h=%b want %h/11 h=0",
                     samp_out, vsamp, halt, mk(0, 1024, 0));
        end
        load(2048, 2048, 3072, 2048, 4'b1000, 5);
        valid_in = 1'b1;
        tick();
        checks++;
        if (samp_out !== mk(0, 1024, 1024) || vsamp !== 2'b11 || halt !== 1'b1) begin
            errors++;
            $display("FAIL b2b_a1 got %h/%b h=%b want %h/11 h=1",
                     samp_out, vsamp, halt, mk(0, 1024, 1024));
        end
        tick();
        valid_in = 1'b0;
        checks++;
        if (samp_out !== mk(2048, 3072, 2048) || vsamp !== 2'b11) begin
            errors++;
            $display("FAIL b2b_b0 got %h/%b want %h/11", samp_out, vsamp, mk(2048, 3072, 2048));
        end
        checks++;
        if (color_out[0] !== SF'(5 * 256 + 7)) begin
            errors++;
            $display("FAIL b2b_color got %h want %h", color_out[0], SF'(5 * 256 + 7));
        end
        tick();
        checks++;
        if (vsamp !== 2'b00 || halt !== 1'b1) begin
            errors++;
            $display("FAIL b2b_done got v=%b h=%b want v=00 h=1", vsamp, halt);
        end
    endtask

    task automatic test_empty_box;
        send(1024, 0, 0, 0, 4'b1000, 6);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (vsamp !== 2'b00 || halt !== 1'b1) begin
                errors++;
                $display("FAIL empty_c%0d got v=%b h=%b want v=00 h=1", i, vsamp, halt);
            end
            tick();
        end
    endtask

    task automatic test_reset_mid;
        send(0, 0, 3072, 1024, 4'b1000, 7);
        tick();
        checks++;
        if (samp_out !== mk(2048, 3072, 0) || vsamp !== 2'b11) begin
            errors++;
            $display("FAIL rstmid_c1 got %h/%b want %h/11", samp_out, vsamp, mk(2048, 3072, 0));
        end
        load(0, 0, 1024, 0, 4'b1000, 8);
        valid_in = 1'b1;
        rst      = 1'b1;
        tick();
        rst      = 1'b0;
        valid_in = 1'b0;
        checks++;
        if (vsamp !== 2'b00 || halt !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_ctl got v=%b h=%b want v=00 h=1", vsamp, halt);
        end
        checks++;
        if (samp_out !== '0 || tri_out !== '0 || color_out !== '0) begin
            errors++;
            $display("FAIL rstmid_data got %h %h %h want 0", samp_out, tri_out, color_out);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (vsamp !== 2'b00 || samp_out !== '0) begin
                errors++;
                $display("FAIL rstmid_after%0d got %h/%b want 0/00", i, samp_out, vsamp);
            end
        end
    endtask

    initial begin
        valid_in = 1'b0;
        rst      = 1'b1;
        load(0, 0, 0, 0, 4'b1000, 0);
        test_reset();
        test_msaa1();
        test_odd_width();
        test_msaa4_snap();
        test_back_to_back();
        test_empty_box();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
